// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request/ready handshake and IF/ID register.
// A one-entry hold buffer keeps a word returned during a hazard stall so it is never refetched.
module fetch_stage #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pcWrite,
  input  logic                   ifIdWrite,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic                   imemReady,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic                   ifIdValid,
  output logic [INSTR_WIDTH-1:0] ifIdInstr,
  output logic [PC_WIDTH-1:0]    ifIdPc,
  output logic [4:0]             ifIdRs,
  output logic [4:0]             ifIdRt
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   ifIdValid_q, ifIdValid_d;
  logic [INSTR_WIDTH-1:0] ifIdInstr_q, ifIdInstr_d;
  logic [PC_WIDTH-1:0]    ifIdPc_q, ifIdPc_d;
  logic [INSTR_WIDTH-1:0] holdInstr_q, holdInstr_d;

  logic stall;
  logic accept;
  logic [PC_WIDTH-1:0] pcNext;

  assign stall  = !pcWrite || !ifIdWrite;
  assign accept = imemReq && imemReady;
  assign pcNext = pc_q + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ifIdValid_q <= 1'b0;
      ifIdInstr_q <= '0;
      ifIdPc_q    <= '0;
      holdInstr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifIdValid_q <= ifIdValid_d;
      ifIdInstr_q <= ifIdInstr_d;
      ifIdPc_q    <= ifIdPc_d;
      holdInstr_q <= holdInstr_d;
    end
  end

  // A redirect overrides everything else, including a word accepted this same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifIdValid_d = ifIdValid_q;
    ifIdInstr_d = ifIdInstr_q;
    ifIdPc_d    = ifIdPc_q;
    holdInstr_d = holdInstr_q;
    if (branchTaken) begin
      state_d     = FETCH;
      pc_d        = branchTarget;
      ifIdValid_d = 1'b0;
      ifIdInstr_d = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (accept && !stall) begin
            ifIdValid_d = 1'b1;
            ifIdInstr_d = imemData;
            ifIdPc_d    = pcNext;
            pc_d        = pcNext;
          end else if (accept) begin
            holdInstr_d = imemData;
            state_d     = HOLD;
          end else if (!stall) begin
            ifIdValid_d = 1'b0;
            ifIdInstr_d = '0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifIdValid_d = 1'b1;
            ifIdInstr_d = holdInstr_q;
            ifIdPc_d    = pcNext;
            pc_d        = pcNext;
            state_d     = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    imemReq = (state_q == FETCH) && !rst;
  end

  assign imemAddr  = pc_q;
  assign ifIdValid = ifIdValid_q;
  assign ifIdInstr = ifIdInstr_q;
  assign ifIdPc    = ifIdPc_q;
  assign ifIdRs    = ifIdInstr_q[25:21];
  assign ifIdRt    = ifIdInstr_q[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued when a cycle is driven
// and popped for comparison after the clock edge that should produce them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite;
  logic        ifIdWrite;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        ifIdValid;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPc;
  logic [4:0]  ifIdRs;
  logic [4:0]  ifIdRt;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] BASE = 32'h0022_1820;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pcWrite      (pcWrite),
    .ifIdWrite    (ifIdWrite),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemReady    (imemReady),
    .imemData     (imemData),
    .ifIdValid    (ifIdValid),
    .ifIdInstr    (ifIdInstr),
    .ifIdPc       (ifIdPc),
    .ifIdRs       (ifIdRs),
    .ifIdRt       (ifIdRt)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word is a fixed pattern plus its own address.
  assign imemData = BASE + imemAddr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic pcw, input logic ifw,
                               input logic br, input logic [31:0] tgt,
                               input logic expV, input logic [31:0] expI, input logic [31:0] expPc);
    exp_t e;
    @(negedge clk);
    rst          = r;
    imemReady    = rdy;
    pcWrite      = pcw;
    ifIdWrite    = ifw;
    branchTaken  = br;
    branchTarget = tgt;
    e.valid = expV;
    e.instr = expI;
    e.pc    = expPc;
    sb.push_back(e);
  endtask

  task automatic endCycle(input string tag, input logic expReq, input logic [31:0] expAddr);
    exp_t e;
    #1;
    checkOutput({tag, ".imemReq"}, {31'd0, imemReq}, {31'd0, expReq});
    checkOutput({tag, ".imemAddr"}, imemAddr, expAddr);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, ".ifIdValid"}, {31'd0, ifIdValid}, {31'd0, e.valid});
      checkOutput({tag, ".ifIdInstr"}, ifIdInstr, e.instr);
      checkOutput({tag, ".ifIdRs"}, {27'd0, ifIdRs}, {27'd0, e.instr[25:21]});
      checkOutput({tag, ".ifIdRt"}, {27'd0, ifIdRt}, {27'd0, e.instr[20:16]});
      if (e.valid) checkOutput({tag, ".ifIdPc"}, ifIdPc, e.pc);
    end
  endtask

  initial begin
    rst = 1'b1; pcWrite = 1'b1; ifIdWrite = 1'b1; branchTaken = 1'b0;
    branchTarget = 32'h0; imemReady = 1'b0;

    // reset held for two cycles
    applyStimulus(1, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);  endCycle("rst0", 0, 32'h0);
    applyStimulus(1, 1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);  endCycle("rst1", 0, 32'h0);

    // zero-wait streaming, one instruction per cycle
    applyStimulus(0, 1, 1, 1, 0, 32'h0, 1, BASE + 32'h0, 32'h4);  endCycle("seq0", 1, 32'h0);
    applyStimulus(0, 1, 1, 1, 0, 32'h0, 1, BASE + 32'h4, 32'h8);  endCycle("seq1", 1, 32'h4);
    applyStimulus(0, 1, 1, 1, 0, 32'h0, 1, BASE + 32'h8, 32'hC);  endCycle("seq2", 1, 32'h8);

    // memory wait states produce bubbles with a stable address
    applyStimulus(0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);         endCycle("wait0", 1, 32'hC);
    applyStimulus(0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);         endCycle("wait1", 1, 32'hC);
    applyStimulus(0, 1, 1, 1, 0, 32'h0, 1, BASE + 32'hC, 32'h10); endCycle("wait2", 1, 32'hC);

    // stall while the word at 0x10 is accepted, then release with memory idle
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 1, BASE + 32'hC, 32'h10);  endCycle("hold0", 1, 32'h10);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 1, BASE + 32'hC, 32'h10);  endCycle("hold1", 0, 32'h10);
    applyStimulus(0, 0, 1, 1, 0, 32'h0, 1, BASE + 32'h10, 32'h14); endCycle("hold2", 0, 32'h10);
    applyStimulus(0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);          endCycle("hold3", 1, 32'h14);

    // redirect in the same cycle a word is returned
    applyStimulus(0, 1, 1, 1, 1, 32'h40, 0, 32'h0, 32'h0);  endCycle("br0", 1, 32'h14);
    applyStimulus(0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);   endCycle("br1", 1, 32'h40);

    // redirect while holding a stalled word; mismatched write enables still stall
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);   endCycle("hbr0", 1, 32'h40);
    applyStimulus(0, 1, 0, 0, 1, 32'h80, 0, 32'h0, 32'h0);  endCycle("hbr1", 0, 32'h40);
    applyStimulus(0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0);   endCycle("hbr2", 1, 32'h80);
    applyStimulus(0, 1, 1, 1, 0, 32'h0, 1, BASE + 32'h80, 32'h84); endCycle("hbr3", 1, 32'h80);

    // reset with a request outstanding, then reset while in HOLD
    applyStimulus(1, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);   endCycle("mrst0", 0, 32'h84);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);   endCycle("mrst1", 1, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);   endCycle("mrst2", 0, 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);   endCycle("mrst3", 1, 32'h0);

    // PC wraps silently at the top of the address space
    applyStimulus(0, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);          endCycle("wrap0", 1, 32'h0);
    applyStimulus(0, 1, 1, 1, 0, 32'h0, 1, BASE + 32'hFFFF_FFFC, 32'h0);   endCycle("wrap1", 1, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);                  endCycle("wrap2", 1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
